// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the registered MIPS main-control decoder.
// Opcodes, the packed control word and the decode function live here.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // MSB first: ALUSrc .. Branch
    typedef struct packed {
        logic alu_src;
        logic mem_to_reg;
        logic reg_dst;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
    } ctrl_t;

    // Unknown opcodes fall through to an all-zero NOP word.
    function automatic ctrl_t decode(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            OP_LW: begin
                c.alu_src    = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
            end
            OP_SW: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            OP_BEQ: begin
                c.branch = 1'b1;
            end
            OP_ADDI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_ctrl_if.sv
// Observation bundle of the fetch/control loop: opcode, control word
// and raw memory read data.
interface mips_ctrl_if;
    import mips_ctrl_pkg::*;

    logic [5:0]  opcode;
    ctrl_t       ctrl;
    logic [15:0] q;

    modport master (output opcode, output ctrl, output q);
    modport slave  (input opcode, input ctrl, input q);

endinterface

// File: rtl/mips_control_unit_memory.sv
// Synchronous single-port RAM with registered address.
// A write and a read of the same address show the new data next cycle.
module memory #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
    logic [ADDR_WIDTH-1:0] r_addr = '0;

    // Store on write enable and capture the read address every edge.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= data;
        end
        r_addr <= addr;
    end

    assign q = r_mem[r_addr];

endmodule

// File: rtl/mips_control_unit_sys.sv
// Fetch/control loop: memory q[15:10] feeds the decoder, MemWrite
// writes i_datain back to i_pc. i_load is a bootstrap write port.
module mips_control_unit_sys
    import mips_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic [9:0]  i_pc,
    input  logic [15:0] i_datain,
    input  logic        i_load,
    mips_ctrl_if.master o_mon
);

    logic [15:0] w_q;
    logic        w_we;
    logic        w_alu_src;
    logic        w_mem_to_reg;
    logic        w_reg_dst;
    logic        w_reg_write;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_branch;

    assign w_we = w_mem_write | i_load;

    memory #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (10)
    ) u_mem (
        .clk  (i_clk),
        .data (i_datain),
        .addr (i_pc),
        .we   (w_we),
        .q    (w_q)
    );

    mips_control_unit u_cu (
        .CLK      (i_clk),
        .Reset    (1'b0),
        .Opcode   (w_q[15:10]),
        .ALUSrc   (w_alu_src),
        .MemtoReg (w_mem_to_reg),
        .RegDst   (w_reg_dst),
        .RegWrite (w_reg_write),
        .MemRead  (w_mem_read),
        .MemWrite (w_mem_write),
        .Branch   (w_branch)
    );

    assign o_mon.opcode = w_q[15:10];
    assign o_mon.q      = w_q;
    assign o_mon.ctrl   = '{
        alu_src:    w_alu_src,
        mem_to_reg: w_mem_to_reg,
        reg_dst:    w_reg_dst,
        reg_write:  w_reg_write,
        mem_read:   w_mem_read,
        mem_write:  w_mem_write,
        branch:     w_branch
    };

endmodule

// File: rtl/mips_control_unit.sv
// Registered main-control decoder: opcode in, seven strobes one
// clock later. Reset clears the pending decode.
module mips_control_unit
    import mips_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    output logic       ALUSrc,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       Branch
);

    ctrl_t w_ctrl;
    ctrl_t r_ctrl = '0;

    // Combinational decode of the current opcode.
    always_comb begin
        w_ctrl = decode(Opcode);
    end

    // Control word register; reset wins over decode.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_ctrl <= '0;
        end else begin
            r_ctrl <= w_ctrl;
        end
    end

    assign ALUSrc   = r_ctrl.alu_src;
    assign MemtoReg = r_ctrl.mem_to_reg;
    assign RegDst   = r_ctrl.reg_dst;
    assign RegWrite = r_ctrl.reg_write;
    assign MemRead  = r_ctrl.mem_read;
    assign MemWrite = r_ctrl.mem_write;
    assign Branch   = r_ctrl.branch;

endmodule

// File: tb/tb_mips_control_unit.sv
// Bench for mips_control_unit, the memory block and the fetch loop.
module tb_mips_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] op  = 6'b000000;

    logic ALUSrc, MemtoReg, RegDst, RegWrite;
    logic MemRead, MemWrite, Branch;
    logic [6:0] dut_ctrl;

    logic [15:0] m_data = '0;
    logic [9:0]  m_addr = '0;
    logic        m_we   = 1'b0;
    logic [15:0] m_q;

    logic [9:0]  s_pc   = '0;
    logic [15:0] s_din  = '0;
    logic        s_load = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;
    bit run    = 1'b0;

    always #5 clk = ~clk;

    mips_control_unit dut (
        .CLK      (clk),
        .Reset    (rst),
        .Opcode   (op),
        .ALUSrc   (ALUSrc),
        .MemtoReg (MemtoReg),
        .RegDst   (RegDst),
        .RegWrite (RegWrite),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .Branch   (Branch)
    );

    assign dut_ctrl = {ALUSrc, MemtoReg, RegDst, RegWrite,
                       MemRead, MemWrite, Branch};

    memory #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) u_mem (
        .clk  (clk),
        .data (m_data),
        .addr (m_addr),
        .we   (m_we),
        .q    (m_q)
    );

    mips_ctrl_if bus ();

    mips_control_unit_sys u_sys (
        .i_clk    (clk),
        .i_pc     (s_pc),
        .i_datain (s_din),
        .i_load   (s_load),
        .o_mon    (bus.master)
    );

    // Reference: each strobe is true for the instruction classes that
    // need it.
    function automatic logic [6:0] ref_ctrl(input logic [5:0] o);
        bit is_r, is_lw, is_sw, is_beq, is_addi;
        is_r    = (o == 6'd0);
        is_lw   = (o == 6'd35);
        is_sw   = (o == 6'd43);
        is_beq  = (o == 6'd4);
        is_addi = (o == 6'd8);
        return {is_lw | is_sw | is_addi,
                is_lw,
                is_r,
                is_r | is_lw | is_addi,
                is_lw,
                is_sw,
                is_beq};
    endfunction

    logic [6:0]  exp_ctrl = '0;
    logic [15:0] mm [1024];
    logic [9:0]  mareg = '0;

    initial begin
        for (int i = 0; i < 1024; i++) mm[i] = '0;
    end

    // Model state advances on the same edge the DUT samples.
    always @(posedge clk) begin
        exp_ctrl <= rst ? 7'd0 : ref_ctrl(op);
        if (m_we) mm[m_addr] <= m_data;
        mareg <= m_addr;
    end

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Per-cycle comparison against the model, away from the edge.
    always @(negedge clk) begin
        if (run) begin
            chk("ctrl_model", {9'd0, dut_ctrl}, {9'd0, exp_ctrl});
            chk("rd_wr_excl", {15'd0, MemRead & MemWrite}, 16'd0);
            chk("mem_model", m_q, mm[mareg]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int nz;

    initial begin
        #1;
        chk("power_up", {9'd0, dut_ctrl}, 16'd0);
        run = 1'b1;

        rst = 1'b1;
        op  = 6'b100011;
        tick();
        chk("reset_1", {9'd0, dut_ctrl}, 16'd0);
        tick();
        chk("reset_2", {9'd0, dut_ctrl}, 16'd0);
        rst = 1'b0;
        tick();
        chk("release_lw", {9'd0, dut_ctrl}, 16'b1101100);

        op = 6'b000000;
        tick();
        chk("rtype", {9'd0, dut_ctrl}, 16'b0011000);
        op = 6'b100011;
        tick();
        chk("lw", {9'd0, dut_ctrl}, 16'b1101100);
        op = 6'b101011;
        tick();
        chk("sw", {9'd0, dut_ctrl}, 16'b1000010);
        op = 6'b000100;
        tick();
        chk("beq", {9'd0, dut_ctrl}, 16'b0000001);
        op = 6'b001000;
        tick();
        chk("addi", {9'd0, dut_ctrl}, 16'b1001000);

        op = 6'b111111;
        tick();
        chk("ill_3f", {9'd0, dut_ctrl}, 16'd0);
        op = 6'b000010;
        tick();
        chk("ill_02", {9'd0, dut_ctrl}, 16'd0);
        op = 6'b100000;
        tick();
        chk("ill_20", {9'd0, dut_ctrl}, 16'd0);

        nz = 0;
        for (int i = 0; i < 64; i++) begin
            op = 6'((i * 37) % 64);
            tick();
            if (dut_ctrl != 7'd0) nz++;
        end
        chk("sweep_nonzero", 16'(nz), 16'd5);

        op = 6'b101011;
        tick();
        chk("mid_sw", {15'd0, MemWrite}, 16'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst", {15'd0, MemWrite}, 16'd0);
        rst = 1'b0;
        tick();
        chk("mid_resume", {15'd0, MemWrite}, 16'd1);

        m_addr = 10'd9;
        tick();
        chk("mem_unwritten", m_q, 16'h0000);
        m_addr = 10'd5;
        m_data = 16'hABCD;
        m_we   = 1'b1;
        tick();
        m_we   = 1'b0;
        m_addr = 10'd6;
        tick();
        m_addr = 10'd5;
        tick();
        chk("mem_rd5", m_q, 16'hABCD);
        m_addr = 10'd7;
        m_data = 16'h1234;
        m_we   = 1'b1;
        tick();
        chk("mem_wr_thru", m_q, 16'h1234);
        m_we = 1'b0;
        tick();
        chk("mem_rd7", m_q, 16'h1234);

        s_pc   = 10'd3;
        s_din  = 16'hAC00;
        s_load = 1'b1;
        tick();
        chk("sys_fetch", bus.q, 16'hAC00);
        s_load = 1'b0;
        s_din  = 16'h8C12;
        tick();
        chk("sys_memwrite", {15'd0, bus.ctrl.mem_write}, 16'd1);
        tick();
        chk("sys_written", bus.q, 16'h8C12);
        tick();
        chk("sys_lw", {9'd0, bus.ctrl}, 16'b1101100);
        tick();
        chk("sys_stable", bus.q, 16'h8C12);

        run = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
